// File: rtl/muldiv_unit.sv
// Iterative RV64M multiply/divide unit: one-bit-per-cycle shift-add multiplier and
// restoring divider, with fast-path handling of divide-by-zero, overflow and bad opcodes.
module muldiv_unit #(
    parameter int unsigned XLEN = 64
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] operand_a,
    input  logic [XLEN-1:0] operand_b,
    input  logic [4:0]      rd_in,
    input  logic            kill,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result,
    output logic [4:0]      rd_out,
    output logic            reg_write
);
    localparam int unsigned CW = $clog2(XLEN) + 1;
    localparam logic [CW-1:0] LastIter = CW'(XLEN - 1);
    localparam logic [XLEN-1:0] MinInt = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

    state_e          state_q, state_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [XLEN-1:0] acc_q, acc_d;
    logic [XLEN-1:0] x_q, x_d;
    logic [XLEN-1:0] y_q, y_d;
    logic            mul_q, mul_d;
    logic            rem_q, rem_d;
    logic            negq_q, negq_d;
    logic            negr_q, negr_d;
    logic            unsup_q, unsup_d;
    logic [XLEN-1:0] result_q, result_d;
    logic [4:0]      rd_q, rd_d;

    // Accept-time decode
    logic            is_div, is_signed, unsup_in, a_neg, b_neg, div_zero, ovf;
    logic [XLEN-1:0] abs_a, abs_b;

    assign is_div    = op[2];
    assign is_signed = op[2] & ~op[0];
    assign unsup_in  = ~op[2] & (op[1:0] != 2'b00);
    assign a_neg     = is_signed & operand_a[XLEN-1];
    assign b_neg     = is_signed & operand_b[XLEN-1];
    assign abs_a     = a_neg ? -operand_a : operand_a;
    assign abs_b     = b_neg ? -operand_b : operand_b;
    assign div_zero  = is_div & (operand_b == '0);
    assign ovf       = is_signed & (operand_a == MinInt) & (operand_b == '1);

    // One iteration. Multiply: acc += x when y[0]; divide: x holds dividend/quotient bits,
    // acc the partial remainder, y the divisor.
    logic [XLEN:0]   shifted, diff;
    logic [XLEN-1:0] acc_it, x_it, y_it, quo_fin, rem_fin;

    always_comb begin
        shifted = {acc_q, x_q[XLEN-1]};
        diff    = shifted - {1'b0, y_q};
        acc_it  = acc_q;
        x_it    = x_q;
        y_it    = y_q;
        if (mul_q) begin
            acc_it = acc_q + (y_q[0] ? x_q : '0);
            x_it   = x_q << 1;
            y_it   = y_q >> 1;
        end else if (!diff[XLEN]) begin
            acc_it = diff[XLEN-1:0];
            x_it   = {x_q[XLEN-2:0], 1'b1};
        end else begin
            acc_it = shifted[XLEN-1:0];
            x_it   = {x_q[XLEN-2:0], 1'b0};
        end
        quo_fin = negq_q ? -x_it : x_it;
        rem_fin = negr_q ? -acc_it : acc_it;
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        x_d      = x_q;
        y_d      = y_q;
        mul_d    = mul_q;
        rem_d    = rem_q;
        negq_d   = negq_q;
        negr_d   = negr_q;
        unsup_d  = unsup_q;
        result_d = result_q;
        rd_d     = rd_q;
        unique case (state_q)
            StIdle: begin
                if (start && !kill) begin
                    rd_d    = rd_in;
                    unsup_d = unsup_in;
                    mul_d   = ~is_div;
                    rem_d   = op[1];
                    negq_d  = a_neg ^ b_neg;
                    negr_d  = a_neg;
                    cnt_d   = '0;
                    acc_d   = '0;
                    x_d     = is_div ? abs_a : operand_a;
                    y_d     = is_div ? abs_b : operand_b;
                    if (unsup_in) begin
                        state_d  = StDone;
                        result_d = '0;
                    end else if (div_zero) begin
                        state_d  = StDone;
                        result_d = op[1] ? operand_a : '1;
                    end else if (ovf) begin
                        state_d  = StDone;
                        result_d = op[1] ? '0 : operand_a;
                    end else begin
                        state_d = StCalc;
                    end
                end
            end
            StCalc: begin
                if (kill) begin
                    state_d = StIdle;
                end else begin
                    acc_d = acc_it;
                    x_d   = x_it;
                    y_d   = y_it;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == LastIter) begin
                        state_d  = StDone;
                        result_d = mul_q ? acc_it : (rem_q ? rem_fin : quo_fin);
                    end
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            acc_q    <= '0;
            x_q      <= '0;
            y_q      <= '0;
            mul_q    <= 1'b0;
            rem_q    <= 1'b0;
            negq_q   <= 1'b0;
            negr_q   <= 1'b0;
            unsup_q  <= 1'b0;
            result_q <= '0;
            rd_q     <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            x_q      <= x_d;
            y_q      <= y_d;
            mul_q    <= mul_d;
            rem_q    <= rem_d;
            negq_q   <= negq_d;
            negr_q   <= negr_d;
            unsup_q  <= unsup_d;
            result_q <= result_d;
            rd_q     <= rd_d;
        end
    end

    assign busy      = (state_q != StIdle);
    assign done      = (state_q == StDone);
    assign result    = result_q;
    assign rd_out    = rd_q;
    // x0 is never written, nor is anything for an unsupported opcode
    assign reg_write = done & (rd_q != 5'd0) & ~unsup_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// Bench for muldiv_unit: directed vector table, randomized ops against an arithmetic model,
// and hand sequences for held start, kill and mid-operation reset.
module tb_muldiv_unit;
    localparam int XLEN = 64;
    localparam logic [63:0] MIN = 64'h8000_0000_0000_0000;

    logic            clk = 1'b0;
    logic            reset, start, kill;
    logic [2:0]      op;
    logic [XLEN-1:0] operand_a, operand_b, result;
    logic [4:0]      rd_in, rd_out;
    logic            busy, done, reg_write;

    muldiv_unit #(.XLEN(XLEN)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op),
        .operand_a(operand_a), .operand_b(operand_b), .rd_in(rd_in), .kill(kill),
        .busy(busy), .done(done), .result(result), .rd_out(rd_out), .reg_write(reg_write)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  op;
        logic [63:0] a;
        logic [63:0] b;
        logic [4:0]  rd;
        logic [63:0] exp_res;
        int          exp_lat;
        logic        exp_rw;
    } vec_t;

    vec_t vecs[$];
    int   pass_cnt = 0;
    int   total_cnt = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    function automatic vec_t mk(input logic [2:0] o, input logic [63:0] a, input logic [63:0] b,
                                input logic [4:0] rd, input logic [63:0] r, input int lat,
                                input logic rw);
        vec_t v;
        v.op = o; v.a = a; v.b = b; v.rd = rd; v.exp_res = r; v.exp_lat = lat; v.exp_rw = rw;
        return v;
    endfunction

    // RV64M semantics from plain arithmetic
    function automatic logic [63:0] model(input logic [2:0] o, input logic [63:0] a,
                                          input logic [63:0] b);
        longint sa, sb;
        sa = a;
        sb = b;
        case (o)
            3'b000: return a * b;
            3'b100: return (b == 0) ? '1 : (a == MIN && b == '1) ? a : 64'(sa / sb);
            3'b101: return (b == 0) ? '1 : a / b;
            3'b110: return (b == 0) ? a : (a == MIN && b == '1) ? 64'd0 : 64'(sa % sb);
            3'b111: return (b == 0) ? a : a % b;
            default: return '0;
        endcase
    endfunction

    function automatic int model_lat(input logic [2:0] o, input logic [63:0] a,
                                     input logic [63:0] b);
        if (o inside {3'b001, 3'b010, 3'b011}) return 0;
        if (o[2] && b == 0) return 0;
        if ((o == 3'b100 || o == 3'b110) && a == MIN && b == '1) return 0;
        return XLEN;
    endfunction

    // Issue one op from IDLE; lat = edges after the accept edge until done is seen
    task automatic do_op(input logic [2:0] o, input logic [63:0] a, input logic [63:0] b,
                         input logic [4:0] rd, output logic [63:0] res, output int lat,
                         output logic rw);
        @(posedge clk); #1;
        op = o; operand_a = a; operand_b = b; rd_in = rd; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        lat = 0;
        while (!done && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        res = result;
        rw  = reg_write;
    endtask

    initial begin
        logic [63:0] res, a, b;
        logic [2:0]  o;
        logic        rw;
        int          lat, dcount;
        logic [2:0]  ops[5] = '{3'b000, 3'b100, 3'b101, 3'b110, 3'b111};

        reset = 1'b1; start = 1'b0; kill = 1'b0; op = '0;
        operand_a = '0; operand_b = '0; rd_in = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        check("reset busy", busy, 0);
        check("reset done", done, 0);
        check("reset result", result, 0);
        check("reset rd_out", rd_out, 0);
        check("reset reg_write", reg_write, 0);

        vecs.push_back(mk(3'b000, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 5'd5,
                          64'hFFFF_FFFF_FFFF_FFEB, 64, 1'b1));
        vecs.push_back(mk(3'b100, -64'd20, 64'd3, 5'd6, 64'hFFFF_FFFF_FFFF_FFFA, 64, 1'b1));
        vecs.push_back(mk(3'b110, -64'd20, 64'd3, 5'd7, 64'hFFFF_FFFF_FFFF_FFFE, 64, 1'b1));
        vecs.push_back(mk(3'b101, 64'd100, 64'd7, 5'd8, 64'd14, 64, 1'b1));
        vecs.push_back(mk(3'b111, 64'd100, 64'd7, 5'd9, 64'd2, 64, 1'b1));
        vecs.push_back(mk(3'b100, 64'h1234, 64'd0, 5'd1, '1, 0, 1'b1));
        vecs.push_back(mk(3'b110, 64'h1234, 64'd0, 5'd2, 64'h1234, 0, 1'b1));
        vecs.push_back(mk(3'b101, 64'h1234, 64'd0, 5'd3, '1, 0, 1'b1));
        vecs.push_back(mk(3'b111, 64'h1234, 64'd0, 5'd4, 64'h1234, 0, 1'b1));
        vecs.push_back(mk(3'b100, MIN, '1, 5'd10, MIN, 0, 1'b1));
        vecs.push_back(mk(3'b110, MIN, '1, 5'd11, 64'd0, 0, 1'b1));
        vecs.push_back(mk(3'b010, 64'd5, 64'd6, 5'd12, 64'd0, 0, 1'b0));
        vecs.push_back(mk(3'b000, 64'd6, 64'd7, 5'd0, 64'd42, 64, 1'b0));

        foreach (vecs[i]) begin
            do_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].rd, res, lat, rw);
            check($sformatf("vec%0d result", i), res, vecs[i].exp_res);
            check($sformatf("vec%0d latency", i), 64'(lat), 64'(vecs[i].exp_lat));
            check($sformatf("vec%0d reg_write", i), rw, vecs[i].exp_rw);
        end

        for (int i = 0; i < 30; i++) begin
            o = ops[$urandom_range(0, 4)];
            a = {$urandom, $urandom};
            b = {$urandom, $urandom};
            case ($urandom_range(0, 5))
                0: b = 64'($urandom_range(0, 9));
                1: b = -64'($urandom_range(1, 9));
                2: a = 64'($urandom_range(0, 1000));
                default: ;
            endcase
            do_op(o, a, b, 5'd17, res, lat, rw);
            check($sformatf("rand%0d op%0d result", i, o), res, model(o, a, b));
            check($sformatf("rand%0d latency", i), 64'(lat), 64'(model_lat(o, a, b)));
        end

        // start held high across a DIVU with rd_in=0
        @(posedge clk); #1;
        op = 3'b101; operand_a = 64'd100; operand_b = 64'd7; rd_in = 5'd0; start = 1'b1;
        @(posedge clk); #1;
        op = 3'b000; operand_a = 64'd555; operand_b = 64'd2; rd_in = 5'd9;
        lat = 0;
        while (!done && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        check("held latency", 64'(lat), 64'(XLEN));
        check("held result", result, 64'd14);
        check("held reg_write", reg_write, 0);
        check("held rd_out", rd_out, 0);
        @(posedge clk); #1;
        check("held idle busy", busy, 0);
        check("held done width", done, 0);
        @(posedge clk); #1;
        check("held reaccept busy", busy, 1);
        check("held reaccept rd_out", rd_out, 9);
        start = 1'b0; kill = 1'b1;
        @(posedge clk); #1;
        kill = 1'b0;
        check("kill busy", busy, 0);
        check("kill done", done, 0);
        check("kill result kept", result, 64'd14);

        // kill in IDLE drops the request
        op = 3'b000; rd_in = 5'd7; start = 1'b1; kill = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; kill = 1'b0;
        check("idle kill busy", busy, 0);
        check("idle kill rd_out", rd_out, 9);

        // kill at cycle 30 of a MUL
        operand_a = 64'd3; operand_b = 64'd5; rd_in = 5'd4; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        dcount = 0;
        repeat (29) begin
            @(posedge clk); #1;
            if (done) dcount++;
        end
        kill = 1'b1;
        @(posedge clk); #1;
        kill = 1'b0;
        if (done) dcount++;
        check("kill30 busy", busy, 0);
        check("kill30 result kept", result, 64'd14);

        // reset at cycle 10 of a new MUL
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) begin
            @(posedge clk); #1;
            if (done) dcount++;
        end
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("abort no done pulse", 64'(dcount), 0);
        check("rst busy", busy, 0);
        check("rst done", done, 0);
        check("rst result", result, 0);
        check("rst rd_out", rd_out, 0);
        check("rst reg_write", reg_write, 0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
